// File: rtl/cola_vend_ctrl.sv
// Cola vending sequencer: coin credit, dispense req/ack handshake, change pulses.
// Optional COLLECT idle auto-refund is enabled by defining VEND_TIMEOUT_EN.
module cola_vend_ctrl #(
    parameter int PRICE    = 5,
    parameter int CREDIT_W = 4,
    parameter int TIMEOUT  = 50_000_000
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                pi_money_half,
    input  logic                pi_money_one,
    input  logic                pi_cancel,
    input  logic                pi_vend_ack,
    output logic                po_vend_req,
    output logic                po_cola,
    output logic                po_change,
    output logic [CREDIT_W-1:0] po_credit,
    output logic                po_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_t;

    localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]   PRICE_EXT  = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C    = PRICE_EXT[CREDIT_W-1:0];
    localparam logic [CREDIT_W-1:0] ONE_C      = {{(CREDIT_W-1){1'b0}}, 1'b1};

    if (PRICE < 1 || PRICE > (2 ** CREDIT_W) - 4 || TIMEOUT < 1) begin : g_bad_param
        $error("cola_vend_ctrl: PRICE or TIMEOUT out of range");
    end

    state_t              state_q, state_d;
    logic                gap_q, gap_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                vend_req_d, cola_d, change_d, busy_d;

    logic [1:0]          coin_val;
    logic                coin_any;
    logic [CREDIT_W:0]   raw_sum;
    logic [CREDIT_W-1:0] sum;
    logic                reach_price;
    logic                to_fire;

    // half + 2*one, so both coins in one cycle give 3
    assign coin_val    = {pi_money_one, pi_money_half};
    assign coin_any    = |coin_val;
    assign raw_sum     = {1'b0, credit_q} + {{(CREDIT_W-1){1'b0}}, coin_val};
    assign sum         = (raw_sum > CREDIT_MAX) ? CREDIT_MAX[CREDIT_W-1:0]
                                                : raw_sum[CREDIT_W-1:0];
    assign reach_price = ({1'b0, sum} >= PRICE_EXT);

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt_q;

    assign to_fire = (state_q == S_COLLECT) && !coin_any && (to_cnt_q == TO_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            to_cnt_q <= '0;
        end else if (state_q != S_COLLECT || state_d != S_COLLECT || coin_any) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        credit_d = sum;
        cola_d   = 1'b0;
        change_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                gap_d = 1'b0;
                if (coin_any) begin
                    if (reach_price) begin
                        state_d  = S_VEND;
                        credit_d = sum - PRICE_C;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                // a coin reaching PRICE beats a simultaneous cancel
                if (reach_price) begin
                    state_d  = S_VEND;
                    credit_d = sum - PRICE_C;
                end else if (pi_cancel || to_fire) begin
                    state_d = S_CHANGE;
                    gap_d   = 1'b0;
                end
            end
            S_VEND: begin
                if (pi_vend_ack) begin
                    cola_d = 1'b1;
                    gap_d  = 1'b0;
                    state_d = (sum != '0) ? S_CHANGE : S_IDLE;
                end
            end
            S_CHANGE: begin
                if (!gap_q) begin
                    change_d = 1'b1;
                    credit_d = sum - ONE_C;
                    gap_d    = 1'b1;
                    // last pulse goes straight to IDLE, no trailing gap
                    if (sum == ONE_C) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = 1'b0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
        vend_req_d = (state_d == S_VEND);
        busy_d     = (state_d == S_VEND) || (state_d == S_CHANGE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            gap_q       <= 1'b0;
            credit_q    <= '0;
            po_vend_req <= 1'b0;
            po_cola     <= 1'b0;
            po_change   <= 1'b0;
            po_busy     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            credit_q    <= credit_d;
            po_vend_req <= vend_req_d;
            po_cola     <= cola_d;
            po_change   <= change_d;
            po_busy     <= busy_d;
        end
    end

    assign po_credit = credit_q;

endmodule

// File: tb/tb_cola_vend_ctrl.sv
// Directed bench for cola_vend_ctrl with PRICE=5, CREDIT_W=4, TIMEOUT=10.
module tb_cola_vend_ctrl;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       pi_money_half;
    logic       pi_money_one;
    logic       pi_cancel;
    logic       pi_vend_ack;
    logic       po_vend_req;
    logic       po_cola;
    logic       po_change;
    logic [3:0] po_credit;
    logic       po_busy;

    int tests;
    int fails;
    int change_cnt;
    int cola_cnt;
    int req_seen;

    cola_vend_ctrl #(
        .PRICE    (5),
        .CREDIT_W (4),
        .TIMEOUT  (10)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .pi_money_half (pi_money_half),
        .pi_money_one  (pi_money_one),
        .pi_cancel     (pi_cancel),
        .pi_vend_ack   (pi_vend_ack),
        .po_vend_req   (po_vend_req),
        .po_cola       (po_cola),
        .po_change     (po_change),
        .po_credit     (po_credit),
        .po_busy       (po_busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (po_change === 1'b1) change_cnt++;
        if (po_cola === 1'b1) cola_cnt++;
        if (po_vend_req === 1'b1) req_seen++;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clr_inputs();
        pi_money_half = 1'b0;
        pi_money_one  = 1'b0;
        pi_cancel     = 1'b0;
        pi_vend_ack   = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) begin
            pi_money_half = 1'($urandom_range(0, 1));
            pi_money_one  = 1'($urandom_range(0, 1));
            pi_cancel     = 1'($urandom_range(0, 1));
            pi_vend_ack   = 1'($urandom_range(0, 1));
            tick();
            tests++;
            if ({po_vend_req, po_cola, po_change, po_busy, po_credit} !== 8'h00) begin
                fails++;
                $display("FAIL reset_hold: outputs=%b want 00000000",
                         {po_vend_req, po_cola, po_change, po_busy, po_credit});
            end
        end
        clr_inputs();
        #3 sys_rst_n = 1'b1;
        change_cnt = 0; cola_cnt = 0; req_seen = 0;
        repeat (3) tick();
        tests++;
        if ({po_vend_req, po_cola, po_change, po_busy, po_credit} !== 8'h00 ||
            change_cnt != 0 || cola_cnt != 0 || req_seen != 0) begin
            fails++;
            $display("FAIL reset_release: outputs=%b pulses=%0d want all 0",
                     {po_vend_req, po_cola, po_change, po_busy, po_credit},
                     change_cnt + cola_cnt + req_seen);
        end
    endtask

    task automatic test_half_coins();
        logic [3:0] exp_cr [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        logic       exp_rq [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        change_cnt = 0; cola_cnt = 0;
        pi_money_half = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (po_credit !== exp_cr[i] || po_vend_req !== exp_rq[i]) begin
                fails++;
                $display("FAIL half_coin%0d: credit=%0d req=%b want credit=%0d req=%b",
                         i, po_credit, po_vend_req, exp_cr[i], exp_rq[i]);
            end
        end
        pi_money_half = 1'b0;
        repeat (3) tick();
        tests++;
        if (po_vend_req !== 1'b1 || po_busy !== 1'b1 || po_cola !== 1'b0) begin
            fails++;
            $display("FAIL half_wait: req=%b busy=%b cola=%b want 1 1 0",
                     po_vend_req, po_busy, po_cola);
        end
        pi_vend_ack = 1'b1;
        tick();
        pi_vend_ack = 1'b0;
        tests++;
        if (po_cola !== 1'b1 || po_vend_req !== 1'b0 || po_credit !== 4'd0 || po_busy !== 1'b0) begin
            fails++;
            $display("FAIL half_ack: cola=%b req=%b credit=%0d busy=%b want 1 0 0 0",
                     po_cola, po_vend_req, po_credit, po_busy);
        end
        repeat (4) tick();
        tests++;
        if (cola_cnt != 1 || change_cnt != 0 || po_cola !== 1'b0) begin
            fails++;
            $display("FAIL half_after: cola_pulses=%0d change_pulses=%0d want 1 0",
                     cola_cnt, change_cnt);
        end
    endtask

    task automatic test_one_coins();
        logic [3:0] exp_cr [3] = '{4'd2, 4'd4, 4'd1};
        logic       exp_rq [3] = '{1'b0, 1'b0, 1'b1};
        pi_money_one = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (po_credit !== exp_cr[i] || po_vend_req !== exp_rq[i]) begin
                fails++;
                $display("FAIL one_coin%0d: credit=%0d req=%b want credit=%0d req=%b",
                         i, po_credit, po_vend_req, exp_cr[i], exp_rq[i]);
            end
        end
        pi_money_one = 1'b0;
        tick();
        change_cnt = 0;
        pi_vend_ack = 1'b1;
        tick();
        pi_vend_ack = 1'b0;
        tests++;
        if (po_cola !== 1'b1 || po_credit !== 4'd1 || po_busy !== 1'b1 || po_change !== 1'b0) begin
            fails++;
            $display("FAIL one_ack: cola=%b credit=%0d busy=%b change=%b want 1 1 1 0",
                     po_cola, po_credit, po_busy, po_change);
        end
        tick();
        tests++;
        if (po_change !== 1'b1 || po_credit !== 4'd0 || po_busy !== 1'b0) begin
            fails++;
            $display("FAIL one_change: change=%b credit=%0d busy=%b want 1 0 0",
                     po_change, po_credit, po_busy);
        end
        repeat (4) tick();
        tests++;
        if (change_cnt != 1 || po_busy !== 1'b0) begin
            fails++;
            $display("FAIL one_count: change_pulses=%0d busy=%b want 1 0", change_cnt, po_busy);
        end
    endtask

    task automatic test_mixed_coin();
        logic       exp_ch [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] exp_cr [4] = '{4'd1, 4'd1, 4'd0, 4'd0};
        logic       exp_bz [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        pi_money_one = 1'b1;
        repeat (2) tick();
        pi_money_half = 1'b1;
        tick();
        clr_inputs();
        tests++;
        if (po_credit !== 4'd2 || po_vend_req !== 1'b1) begin
            fails++;
            $display("FAIL mixed_vend: credit=%0d req=%b want 2 1", po_credit, po_vend_req);
        end
        tick();
        change_cnt = 0;
        pi_vend_ack = 1'b1;
        tick();
        pi_vend_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (po_change !== exp_ch[i] || po_credit !== exp_cr[i] || po_busy !== exp_bz[i]) begin
                fails++;
                $display("FAIL mixed_change%0d: change=%b credit=%0d busy=%b want %b %0d %b",
                         i, po_change, po_credit, po_busy, exp_ch[i], exp_cr[i], exp_bz[i]);
            end
        end
        tests++;
        if (change_cnt != 2) begin
            fails++;
            $display("FAIL mixed_count: change_pulses=%0d want 2", change_cnt);
        end
    endtask

    task automatic test_cancel();
        logic       exp_ch [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] exp_cr [6] = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0};
        logic       exp_bz [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        req_seen = 0; change_cnt = 0;
        pi_money_one = 1'b1;
        tick();
        pi_money_one = 1'b0;
        pi_money_half = 1'b1;
        tick();
        pi_money_half = 1'b0;
        pi_cancel = 1'b1;
        tick();
        pi_cancel = 1'b0;
        tests++;
        if (po_credit !== 4'd3 || po_busy !== 1'b1 || po_change !== 1'b0) begin
            fails++;
            $display("FAIL cancel_entry: credit=%0d busy=%b change=%b want 3 1 0",
                     po_credit, po_busy, po_change);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (po_change !== exp_ch[i] || po_credit !== exp_cr[i] || po_busy !== exp_bz[i]) begin
                fails++;
                $display("FAIL cancel_change%0d: change=%b credit=%0d busy=%b want %b %0d %b",
                         i, po_change, po_credit, po_busy, exp_ch[i], exp_cr[i], exp_bz[i]);
            end
        end
        tests++;
        if (change_cnt != 3 || req_seen != 0) begin
            fails++;
            $display("FAIL cancel_count: change_pulses=%0d req_cycles=%0d want 3 0",
                     change_cnt, req_seen);
        end
    endtask

    task automatic test_priority();
        change_cnt = 0;
        pi_money_one = 1'b1;
        repeat (2) tick();
        pi_cancel = 1'b1;
        tick();
        clr_inputs();
        tests++;
        if (po_vend_req !== 1'b1 || po_credit !== 4'd1) begin
            fails++;
            $display("FAIL prio_coin_wins: req=%b credit=%0d want 1 1", po_vend_req, po_credit);
        end
        pi_cancel = 1'b1;
        tick();
        pi_cancel = 1'b0;
        pi_money_half = 1'b1;
        tick();
        pi_money_half = 1'b0;
        tests++;
        if (po_vend_req !== 1'b1 || po_credit !== 4'd2 || po_change !== 1'b0) begin
            fails++;
            $display("FAIL prio_vend_hold: req=%b credit=%0d change=%b want 1 2 0",
                     po_vend_req, po_credit, po_change);
        end
        pi_vend_ack = 1'b1;
        tick();
        pi_vend_ack = 1'b0;
        repeat (5) tick();
        tests++;
        if (change_cnt != 2 || po_credit !== 4'd0 || po_busy !== 1'b0) begin
            fails++;
            $display("FAIL prio_refund: change_pulses=%0d credit=%0d busy=%b want 2 0 0",
                     change_cnt, po_credit, po_busy);
        end
    endtask

    task automatic test_ignored_inputs();
        cola_cnt = 0; change_cnt = 0;
        pi_vend_ack = 1'b1;
        tick();
        pi_vend_ack = 1'b0;
        pi_cancel = 1'b1;
        tick();
        pi_cancel = 1'b0;
        tick();
        tests++;
        if (cola_cnt != 0 || change_cnt != 0 || po_busy !== 1'b0 || po_credit !== 4'd0) begin
            fails++;
            $display("FAIL idle_ignore: cola=%0d change=%0d busy=%b credit=%0d want 0 0 0 0",
                     cola_cnt, change_cnt, po_busy, po_credit);
        end
        pi_money_half = 1'b1;
        tick();
        pi_money_half = 1'b0;
        pi_vend_ack = 1'b1;
        tick();
        pi_vend_ack = 1'b0;
        tests++;
        if (po_cola !== 1'b0 || po_vend_req !== 1'b0 || po_credit !== 4'd1) begin
            fails++;
            $display("FAIL collect_ack: cola=%b req=%b credit=%0d want 0 0 1",
                     po_cola, po_vend_req, po_credit);
        end
        pi_cancel = 1'b1;
        tick();
        pi_cancel = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_in_vend();
        pi_money_one = 1'b1;
        repeat (3) tick();
        pi_money_one = 1'b0;
        tests++;
        if (po_vend_req !== 1'b1) begin
            fails++;
            $display("FAIL rstv_pre: req=%b want 1", po_vend_req);
        end
        #2 sys_rst_n = 1'b0;
        #1;
        tests++;
        if (po_vend_req !== 1'b0 || po_credit !== 4'd0 || po_busy !== 1'b0) begin
            fails++;
            $display("FAIL rstv_async: req=%b credit=%0d busy=%b want 0 0 0",
                     po_vend_req, po_credit, po_busy);
        end
        tick();
        #2 sys_rst_n = 1'b1;
        cola_cnt = 0;
        pi_vend_ack = 1'b1;
        tick();
        pi_vend_ack = 1'b0;
        tick();
        tests++;
        if (cola_cnt != 0 || po_vend_req !== 1'b0 || po_busy !== 1'b0) begin
            fails++;
            $display("FAIL rstv_after: cola=%0d req=%b busy=%b want 0 0 0",
                     cola_cnt, po_vend_req, po_busy);
        end
    endtask

    task automatic test_timeout();
        pi_money_one = 1'b1;
        tick();
        pi_money_one = 1'b0;
        change_cnt = 0;
`ifdef VEND_TIMEOUT_EN
        repeat (9) tick();
        tests++;
        if (po_busy !== 1'b0 || po_credit !== 4'd2) begin
            fails++;
            $display("FAIL to_early: busy=%b credit=%0d want 0 2", po_busy, po_credit);
        end
        tick();
        tests++;
        if (po_busy !== 1'b1 || po_credit !== 4'd2) begin
            fails++;
            $display("FAIL to_fire: busy=%b credit=%0d want 1 2", po_busy, po_credit);
        end
        repeat (4) tick();
        tests++;
        if (change_cnt != 2 || po_credit !== 4'd0 || po_busy !== 1'b0) begin
            fails++;
            $display("FAIL to_refund: change_pulses=%0d credit=%0d busy=%b want 2 0 0",
                     change_cnt, po_credit, po_busy);
        end
`else
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (po_credit !== 4'd2 || po_busy !== 1'b0) bad++;
            end
            tests++;
            if (bad != 0 || change_cnt != 0) begin
                fails++;
                $display("FAIL no_timeout: bad_cycles=%0d change_pulses=%0d credit=%0d want 0 0 2",
                         bad, change_cnt, po_credit);
            end
        end
        pi_cancel = 1'b1;
        tick();
        pi_cancel = 1'b0;
        repeat (4) tick();
        tests++;
        if (change_cnt != 2 || po_credit !== 4'd0) begin
            fails++;
            $display("FAIL no_timeout_cancel: change_pulses=%0d credit=%0d want 2 0",
                     change_cnt, po_credit);
        end
`endif
    endtask

    initial begin
        tests = 0; fails = 0;
        change_cnt = 0; cola_cnt = 0; req_seen = 0;
        sys_rst_n = 1'b0;
        clr_inputs();
        test_reset();
        test_half_coins();
        test_one_coins();
        test_mixed_coin();
        test_cancel();
        test_priority();
        test_ignored_inputs();
        test_reset_in_vend();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cola_vend_ctrl.md
Name: cola_vend_ctrl

Overview:
Sequencing controller for the cola vending path. Accepts 0.5-unit and 1-unit coin pulses, accumulates credit and requests one dispense from the dispenser mechanism through a req/ack handshake once credit reaches PRICE. It then returns any remaining credit as change pulses. It sits between the coin acceptor and the dispenser/change hopper; its po_cola pulse is the cycle-compatible counterpart of the existing out_cola output.

Parameters:
PRICE, 5, cola price in half-units (5 = 2.5); legal range 1..(2^CREDIT_W - 4)
CREDIT_W, 4, credit register width in half-units
TIMEOUT, 50_000_000, idle cycles in COLLECT before auto-refund (used only with the optional feature)

Ports:
sys_clk  in  1  system clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
pi_money_half  in  1  one-cycle pulse, 0.5 coin inserted (+1 half-unit)
pi_money_one  in  1  one-cycle pulse, 1.0 coin inserted (+2 half-units)
pi_cancel  in  1  one-cycle pulse, refund request
pi_vend_ack  in  1  dispenser completion, one-cycle pulse
po_vend_req  out  1  dispense request, level, held until ack
po_cola  out  1  one-cycle pulse, cola delivered
po_change  out  1  one-cycle pulse per half-unit returned
po_credit  out  CREDIT_W  current credit in half-units
po_busy  out  1  high in VEND or CHANGE

Behaviour:
- Reset (async, sys_rst_n low): state IDLE, credit 0, all outputs 0, timeout counter 0. Takes effect immediately, including mid-VEND (po_vend_req drops without waiting for ack) and mid-CHANGE (remaining credit is lost).
- Coin value per cycle: half + 2*one. Both pulses in the same cycle add 3. Coins are accepted in every state.
- credit_next = credit + coin value, saturating at 2^CREDIT_W-1. All outputs are registered. po_credit reflects credit_next one cycle after the sampling edge.
- IDLE:
  - coin value > 0: go to COLLECT, or straight to VEND if credit_next >= PRICE.
  - pi_cancel with credit 0: ignored.
- COLLECT:
  - On the edge where credit_next >= PRICE: state <= VEND, credit <= credit_next - PRICE. po_vend_req is high from the next cycle. Latency is 1 cycle from the coin pulse.
  - pi_cancel (no coin reaching PRICE in the same cycle): go to CHANGE with the full credit_next.
  - A coin that reaches PRICE wins over a simultaneous cancel; the remainder is refunded after vending.
- VEND:
  - po_vend_req = 1. pi_cancel is ignored. Coins arriving now add to the remainder, which is refunded.
  - On pi_vend_ack: po_vend_req <= 0 and po_cola <= 1 for one cycle. Next state is CHANGE if credit (including any coin in the ack cycle) > 0, else IDLE.
  - pi_vend_ack outside VEND is ignored.
- CHANGE:
  - Alternates a pulse cycle and a gap cycle. po_change is high for 1 cycle, low for 1 cycle. Credit decrements on each pulse.
  - First pulse is in the cycle after entry. Coins arriving now extend the refund.
  - When credit reaches 0 after a pulse, go to IDLE. There is no gap cycle after the final pulse.
- po_busy = (state == VEND) || (state == CHANGE).

Optional Feature:
Macro: VEND_TIMEOUT_EN.
- Defined:
  - A counter runs in COLLECT, clears on any coin and on leaving COLLECT.
  - When it reaches TIMEOUT-1 with no coin in that cycle: go to CHANGE and refund the full credit.
  - Counter width is $clog2(TIMEOUT+1).
- Not defined: no counter is synthesized, and COLLECT waits indefinitely.

Test Plan:
1. Hold reset 2 cycles with random coin pulses -> all outputs 0, po_credit 0. Release -> IDLE, no spurious pulses.
2. PRICE=5, five pi_money_half pulses on consecutive cycles -> po_vend_req rises 1 cycle after the 5th pulse. Ack 3 cycles later -> one po_cola pulse, po_credit 0, zero po_change, IDLE.
3. Three pi_money_one pulses -> VEND after the 3rd with remainder 1. After ack -> exactly one po_change pulse, then IDLE.
4. Credit 4, pi_money_half and pi_money_one in the same cycle -> VEND with remainder 2. After ack -> two po_change pulses separated by one gap cycle.
5. Credit 3 then pi_cancel -> three po_change pulses, no po_vend_req, then IDLE.
6. Assert reset during VEND -> po_vend_req low asynchronously, credit 0.
7. With VEND_TIMEOUT_EN and TIMEOUT=10: credit 2, then no coins for 10 cycles -> CHANGE, two po_change pulses. Without the macro, credit stays at 2 for 100 cycles.
